// File: rtl/vend_pkg.sv
// Shared definitions for the vending machine coin path (intake and change dispenser).
// Coin bit order is nickel, dime, quarter, dollar from bit 0 upward.
package vend_pkg;

  localparam int NICKEL  = 0;
  localparam int DIME    = 1;
  localparam int QUARTER = 2;
  localparam int DOLLAR  = 3;

  // Coin values in nickel units
  localparam int unsigned NICKEL_VAL  = 1;
  localparam int unsigned DIME_VAL    = 2;
  localparam int unsigned QUARTER_VAL = 5;
  localparam int unsigned DOLLAR_VAL  = 20;

  localparam int COIN_VAL_W = 5;

  localparam int unsigned COIN_VAL [4] = '{NICKEL_VAL, DIME_VAL, QUARTER_VAL, DOLLAR_VAL};

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ISSUE,
    RELEASE,
    DONE,
    FAULT
  } disp_state_t;

endpackage

// File: rtl/vend_coin_select.sv
// Greedy change picker: largest stocked coin whose value fits in the amount still owed.
module vend_coin_select
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0]   remaining,
  input  logic [3:0]            coin_empty,
  output logic [3:0]            coin,
  output logic [COIN_VAL_W-1:0] value,
  output logic                  valid
);

  always_comb begin
    coin  = '0;
    value = '0;
    valid = 1'b0;
    // Scan from the dollar down; the first hit wins
    for (int b = DOLLAR; b >= NICKEL; b--) begin
      if (!valid && !coin_empty[b] && (32'(remaining) >= 32'(COIN_VAL[b]))) begin
        coin[b] = 1'b1;
        value   = COIN_VAL_W'(COIN_VAL[b]);
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_change_dispenser.sv
// Change payout controller: dispenses one coin at a time over a 4-phase req/ack
// handshake with the hopper, largest denomination first, with per-phase timeout.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int CREDIT_W    = 8,
  parameter int ACK_TIMEOUT = 5000000
) (
  input  logic                CLK50M,
  input  logic                RSTb,
  input  logic                start,
  input  logic [CREDIT_W-1:0] credit,
  input  logic                coin_ack,
  input  logic [3:0]          coin_empty,
  input  logic                fault_clr,
  output logic [3:0]          coin_out,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [CREDIT_W-1:0] remaining
);

  localparam int TIMER_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(ACK_TIMEOUT - 1);

  disp_state_t           state_q, state_d;
  logic [CREDIT_W-1:0]   remaining_q, remaining_d;
  logic [3:0]            coin_out_q, coin_out_d;
  logic [COIN_VAL_W-1:0] coin_val_q, coin_val_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fault_q, fault_d;

  logic [3:0]            sel_coin;
  logic [COIN_VAL_W-1:0] sel_value;
  logic                  sel_valid;

  vend_coin_select #(
    .CREDIT_W (CREDIT_W)
  ) u_select (
    .remaining  (remaining_q),
    .coin_empty (coin_empty),
    .coin       (sel_coin),
    .value      (sel_value),
    .valid      (sel_valid)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_out_d  = coin_out_q;
    coin_val_d  = coin_val_q;
    timer_d     = timer_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = credit;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        if (remaining_q == '0) begin
          state_d = DONE;
        end else if (sel_valid) begin
          coin_out_d = sel_coin;
          coin_val_d = sel_value;
          timer_d    = '0;
          state_d    = ISSUE;
        end else begin
          state_d = FAULT;
        end
      end
      ISSUE: begin
        // The coin is only debited once the hopper has acknowledged it
        if (coin_ack) begin
          coin_out_d  = '0;
          remaining_d = remaining_q - CREDIT_W'(coin_val_q);
          timer_d     = '0;
          state_d     = RELEASE;
        end else if (timer_q == TIMER_MAX) begin
          coin_out_d = '0;
          state_d    = FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!coin_ack) begin
          state_d = SELECT;
        end else if (timer_q == TIMER_MAX) begin
          state_d = FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      FAULT: begin
        coin_out_d = '0;
        if (fault_clr) begin
          remaining_d = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        coin_out_d = '0;
        state_d    = IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up with it
    busy_d  = (state_d != IDLE) && (state_d != FAULT);
    done_d  = (state_d == DONE);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge CLK50M or negedge RSTb) begin
    if (!RSTb) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      coin_out_q  <= '0;
      coin_val_q  <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_out_q  <= coin_out_d;
      coin_val_q  <= coin_val_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign coin_out  = coin_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Scoreboard bench for the change dispenser: a greedy reference model queues the
// expected coin/terminal events and a negedge monitor compares what the DUT shows.
module tb_vend_change_dispenser;

  localparam int CW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] credit = '0;
  logic          coin_ack = 1'b0;
  logic [3:0]    coin_empty = '0;
  logic          fault_clr = 1'b0;
  logic [3:0]    coin_out;
  logic          busy, done, fault;
  logic [CW-1:0] remaining;

  int checks = 0;
  int passes = 0;

  // kind: 0 = coin issued, 1 = done, 2 = fault; val = amount owed at that point
  typedef struct {
    int kind;
    int val;
    int coin;
  } ev_t;
  ev_t sb_q[$];

  // Hopper behaviour: 0 = normal handshake, 1 = never acks, 2 = ack stuck high
  int ack_mode = 0;
  int ack_dly = 2;
  int rel_dly = 1;
  int hcnt = 0;

  always #10 clk = ~clk;

  vend_change_dispenser #(
    .CREDIT_W    (CW),
    .ACK_TIMEOUT (TO)
  ) dut (
    .CLK50M     (clk),
    .RSTb       (rst_n),
    .start      (start),
    .credit     (credit),
    .coin_ack   (coin_ack),
    .coin_empty (coin_empty),
    .fault_clr  (fault_clr),
    .coin_out   (coin_out),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .remaining  (remaining)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic pop_ev(input int kind_seen, output ev_t e, output bit ok);
    if (sb_q.size() == 0) begin
      checks++;
      $display("FAIL sb_unexpected: got event kind %0d expected none", kind_seen);
      ok = 1'b0;
      e.kind = -1; e.val = 0; e.coin = 0;
    end else begin
      e = sb_q.pop_front();
      ok = 1'b1;
      check("event_kind", kind_seen, e.kind);
    end
  endtask

  // Reference: pay greedily from the stocked denominations using plain arithmetic
  task automatic model_push(input int cr, input logic [3:0] empty);
    int vals[4] = '{1, 2, 5, 20};
    int rem;
    int pick;
    ev_t e;
    rem = cr;
    while (rem > 0) begin
      pick = -1;
      for (int b = 3; b >= 0; b--)
        if (pick < 0 && !empty[b] && vals[b] <= rem) pick = b;
      if (pick < 0) break;
      e.kind = 0; e.coin = 1 << pick; e.val = rem;
      sb_q.push_back(e);
      rem -= vals[pick];
    end
    e.kind = (rem == 0) ? 1 : 2; e.val = rem; e.coin = 0;
    sb_q.push_back(e);
  endtask

  task automatic push_ev(input int kind, input int val, input int coin);
    ev_t e;
    e.kind = kind; e.val = val; e.coin = coin;
    sb_q.push_back(e);
  endtask

  // Hopper model
  always @(negedge clk) begin
    case (ack_mode)
      0: begin
        if (coin_out != 0 && !coin_ack) begin
          hcnt++;
          if (hcnt >= ack_dly) begin coin_ack = 1'b1; hcnt = 0; end
        end else if (coin_out == 0 && coin_ack) begin
          hcnt++;
          if (hcnt >= rel_dly) begin coin_ack = 1'b0; hcnt = 0; end
        end else hcnt = 0;
      end
      1: begin coin_ack = 1'b0; hcnt = 0; end
      default: if (coin_out != 0) coin_ack = 1'b1;
    endcase
  end

  // Monitor
  logic [3:0] prev_coin = '0;
  logic       prev_done = 1'b0;
  logic       prev_fault = 1'b0;

  always @(negedge clk) begin : mon
    ev_t e;
    bit ok;
    if (rst_n) begin
      if (coin_out != 0 && prev_coin == 0) begin
        pop_ev(0, e, ok);
        if (ok) begin
          check("coin_out", int'(coin_out), e.coin);
          check("remaining_at_coin", int'(remaining), e.val);
        end
      end else if (coin_out != 0) begin
        check("coin_out_stable", int'(coin_out), int'(prev_coin));
      end
      if (done) begin
        check("done_one_cycle", int'(prev_done), 0);
        if (!prev_done) begin
          pop_ev(1, e, ok);
          if (ok) check("remaining_at_done", int'(remaining), e.val);
        end
      end
      if (fault && !prev_fault) begin
        pop_ev(2, e, ok);
        if (ok) check("remaining_at_fault", int'(remaining), e.val);
        check("coin_out_in_fault", int'(coin_out), 0);
        check("busy_in_fault", int'(busy), 0);
      end
    end
    prev_coin  = coin_out;
    prev_done  = done;
    prev_fault = fault;
  end

  task automatic pulse_start(input int cr);
    @(negedge clk);
    credit = CW'(cr);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic clear_fault();
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    #1;
    check("clr_fault", int'(fault), 0);
    check("clr_remaining", int'(remaining), 0);
    check("clr_busy", int'(busy), 0);
  endtask

  task automatic run_txn(input int cr, input logic [3:0] empty, input bit extra_start);
    bit finished;
    coin_empty = empty;
    model_push(cr, empty);
    pulse_start(cr);
    finished = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      if (extra_start && i == 3) begin
        start  = 1'b1;
        credit = CW'(99);
      end else begin
        start = 1'b0;
      end
      if (sb_q.size() == 0 && !busy) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("txn_finished", int'(finished), 1);
    if (!finished) sb_q.delete();
    if (fault) clear_fault();
  endtask

  initial begin
    int ncyc;
    bit got;

    repeat (3) @(negedge clk);
    #1;
    check("rst_coin_out", int'(coin_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_remaining", int'(remaining), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed payouts
    ack_mode = 0; ack_dly = 2; rel_dly = 1;
    run_txn(27, 4'b0000, 1'b0);
    run_txn(5, 4'b0100, 1'b0);
    run_txn(3, 4'b0001, 1'b0);

    // Zero credit: SELECT then DONE
    coin_empty = '0;
    model_push(0, 4'b0000);
    pulse_start(0);
    #1;
    check("c0_select_busy", int'(busy), 1);
    check("c0_select_done", int'(done), 0);
    @(negedge clk); #1;
    check("c0_done", int'(done), 1);
    check("c0_coin_out", int'(coin_out), 0);
    @(negedge clk); #1;
    check("c0_idle_busy", int'(busy), 0);
    check("c0_sb_empty", sb_q.size(), 0);

    // Second start while busy is ignored
    ack_dly = 4; rel_dly = 2;
    run_txn(27, 4'b0000, 1'b1);

    // ISSUE timeout with no ack
    ack_mode = 1;
    push_ev(0, 1, 1);
    push_ev(2, 1, 0);
    pulse_start(1);
    ncyc = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (coin_out == 4'b0001) ncyc++;
      if (fault) begin got = 1'b1; break; end
    end
    check("issue_timeout_seen", int'(got), 1);
    check("issue_timeout_cycles", ncyc, TO);
    check("issue_timeout_remaining", int'(remaining), 1);
    start = 1'b1; credit = CW'(50);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); #1;
    check("fault_ignores_start", int'(fault), 1);
    check("fault_remaining_frozen", int'(remaining), 1);
    clear_fault();

    // RELEASE timeout with ack stuck high
    ack_mode = 2;
    push_ev(0, 1, 1);
    push_ev(2, 0, 0);
    pulse_start(1);
    ncyc = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (coin_ack && busy && coin_out == 0) ncyc++;
      if (fault) begin got = 1'b1; break; end
    end
    check("release_timeout_seen", int'(got), 1);
    check("release_timeout_cycles", ncyc, TO);
    check("release_timeout_coin_out", int'(coin_out), 0);
    clear_fault();
    ack_mode = 1;
    repeat (2) @(negedge clk);

    // Asynchronous reset during ISSUE
    push_ev(0, 1, 1);
    pulse_start(1);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (coin_out != 0) begin got = 1'b1; break; end
    end
    check("issue_reached", int'(got), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_coin_out", int'(coin_out), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_fault", int'(fault), 0);
    check("arst_done", int'(done), 0);
    check("arst_remaining", int'(remaining), 0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized payouts against the model
    ack_mode = 0;
    for (int t = 0; t < 30; t++) begin
      int cr;
      logic [3:0] emp;
      cr = $urandom_range(0, 100);
      emp = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      ack_dly = $urandom_range(1, 5);
      rel_dly = $urandom_range(1, 5);
      run_txn(cr, emp, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
- Payout side of the vending machine: coin intake adds credit, and this block returns change by driving the coin hopper.
- Takes a change amount in nickel units and issues one coin at a time, largest denomination first, over a 4-phase req/ack handshake.
- Skips denominations whose hopper tube is empty, and flags a fault when exact change cannot be made or the hopper stops responding.
- Coin bit order matches the coin intake encoding: bit0 nickel, bit1 dime, bit2 quarter, bit3 dollar.

Parameters:
- CREDIT_W, 8: width of the change amount in nickel units (max 255 = $12.75).
- ACK_TIMEOUT, 5000000: cycles allowed per handshake phase before fault (100 ms at 50 MHz).

Ports:
- CLK50M  in  1  system clock; all state changes on the rising edge.
- RSTb  in  1  reset, asynchronous assert, active-low.
- start  in  1  1-cycle request to dispense `credit`; sampled only in IDLE.
- credit  in  CREDIT_W  change amount in nickels; latched when start is accepted.
- coin_ack  in  1  hopper acknowledge; high = coin ejected.
- coin_empty  in  4  per-denomination tube empty, same bit order as coin_out.
- fault_clr  in  1  1-cycle clear; leaves FAULT for IDLE.
- coin_out  out  4  one-hot coin request to hopper; all-zero when idle.
- busy  out  1  high in every state except IDLE and FAULT.
- done  out  1  1-cycle pulse when remaining reaches 0.
- fault  out  1  high while in FAULT.
- remaining  out  CREDIT_W  change still owed.

Behaviour:
- Reset (RSTb=0, asynchronous): state=IDLE, coin_out=0, busy=0, done=0, fault=0, remaining=0, timeout counter=0.
- All outputs are registered.
- Coin values in nickel units: nickel=1, dime=2, quarter=5, dollar=20.
- IDLE:
  - start=1: remaining<=credit; go to SELECT.
  - start=0: stay. start in any other state is ignored.
- SELECT (one cycle):
  - remaining==0: go to DONE.
  - Otherwise pick the largest coin with value<=remaining and coin_empty[bit]=0, register it on coin_out, clear the timer, go to ISSUE.
  - No coin qualifies: go to FAULT (remaining keeps the unpaid amount).
- ISSUE:
  - coin_out held stable.
  - coin_ack=1: coin_out<=0, remaining<=remaining-value, timer cleared, go to RELEASE.
  - Timer reaches ACK_TIMEOUT-1 with coin_ack=0: go to FAULT.
  - coin_empty changes during ISSUE are ignored; the selection is frozen.
- RELEASE:
  - coin_ack=0: go to SELECT.
  - Timer reaches ACK_TIMEOUT-1: go to FAULT.
- DONE: done=1 for exactly one cycle, then IDLE.
- FAULT:
  - coin_out=0, fault=1, busy=0, remaining frozen.
  - fault_clr=1: go to IDLE, remaining<=0.
  - start is ignored.
- Latency: credit=0 gives done two cycles after start is accepted (SELECT, then DONE). Each coin costs SELECT + ISSUE + RELEASE, at least 3 cycles.
- Subtraction never underflows, because a coin is selected only when value<=remaining.
- Reset mid-handshake drops coin_out immediately. No coin is counted unless its ack was seen.
- coin_ack already high on entry to SELECT cannot happen, because RELEASE waits for ack low.
- Timer width is $clog2(ACK_TIMEOUT); the timer saturates and never wraps.

Decomposition:
- Package vend_pkg holds:
  - coin bit index constants (NICKEL=0, DIME=1, QUARTER=2, DOLLAR=3);
  - coin value constants;
  - typedef enum for disp_state_t {IDLE, SELECT, ISSUE, RELEASE, DONE, FAULT}.
- The coin intake logic will also import vend_pkg.
- One sub-module, vend_coin_select: combinational greedy picker.
  - Inputs: remaining, coin_empty.
  - Outputs: one-hot coin, coin value, valid.

Test Plan:
- credit=27 ($1.35), hopper full, ack returned 2 cycles after each coin_out:
  - coin_out sequence 4'b1000, 4'b0100, 4'b0010;
  - remaining 27→7→2→0;
  - one done pulse; fault=0.
- credit=5, coin_empty=4'b0100 (no quarters):
  - coin_out sequence 4'b0010, 4'b0010, 4'b0001;
  - done pulse.
- credit=3, coin_empty=4'b0001 (no nickels):
  - one dime dispensed, then FAULT with remaining=1;
  - fault_clr returns to IDLE with remaining=0.
- ACK_TIMEOUT=16, credit=1, coin_ack held 0:
  - coin_out=4'b0001 for 16 cycles, then coin_out=0, fault=1.
  - Repeat with ack stuck high in RELEASE: same fault result.
- Reset and start edge cases:
  - Assert RSTb=0 mid-ISSUE: coin_out=0 with no clock edge; all outputs at reset values.
  - Second start while busy: ignored, and the original payout completes unchanged.
  - credit=0: done pulse 2 cycles after start, no coin_out activity.
